regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the RV32 pipeline; successor to the 2R/1W file.
//  Sits between ID (reads) and WB (writes); adds a second write port, N read ports, write-through
//  bypass from both write ports, optional registered reads, a pending-write scoreboard for hazard
//  detection, and a post-reset clear sequencer that zeroes the array one entry per cycle.
// PARAMETERS
//  XLEN      32  data width
//  NREG      32  number of registers (power of 2, >=4); entry 0 hardwired to zero
//  NRP       2   number of read ports (1..4)
//  READ_REG  0   0 = combinational read, 1 = registered read (1-cycle latency)
//  AW        $clog2(NREG)  derived address width (localparam)
// PORTS
//  clk          in   1         clock
//  rst          in   1         reset, synchronous, active-high
//  re_i         in   NRP       per-port read enable
//  raddr_i      in   NRP*AW    read addresses, port k at [k*AW +: AW]
//  rdata_o      out  NRP*XLEN  read data, port k at [k*XLEN +: XLEN]
//  rpend_o      out  NRP       scoreboard pending bit of each read address (0 for addr 0)
//  we0_i        in   1         write port 0 enable (older instruction)
//  waddr0_i     in   AW        write port 0 address
//  wdata0_i     in   XLEN      write port 0 data
//  we1_i        in   1         write port 1 enable (younger instruction, wins on conflict)
//  waddr1_i     in   AW        write port 1 address
//  wdata1_i     in   XLEN      write port 1 data
//  sb_set_i     in   1         issue: mark sb_addr_i as pending writeback
//  sb_addr_i    in   AW        scoreboard set address
//  ready_o      out  1         1 = clear sequence done, file usable
// BEHAVIOUR
//  Reset: rst=1 at a clk edge -> FSM=CLEAR, clear index=0, all scoreboard bits 0, ready_o=0,
//   registered rdata_o (READ_REG=1) = 0. rst asserted mid-CLEAR restarts the sequence at index 0.
//  FSM: CLEAR: write 0 to entry[idx], idx++; at idx==NREG-1 go READY next edge (NREG cycles total).
//   READY: normal operation; stays until rst. ready_o=1 only in READY.
//  In CLEAR: we0/we1/sb_set ignored; all rdata_o=0, rpend_o=0.
//  Writes (READY): on edge, entry[waddrN]<=wdataN if weN and waddrN!=0.
//   Both ports same nonzero addr: port 1 value stored.
//  Read value per port k (READY): raddr==0 -> 0; re=0 -> 0; we1&&waddr1==raddr -> wdata1;
//   else we0&&waddr0==raddr -> wdata0; else entry[raddr]. Bypass applies same-cycle.
//  READ_REG=0: rdata_o combinational from above. READ_REG=1: value captured at edge, visible
//   next cycle (bypass still uses write ports in the capture cycle).
//  Scoreboard: bit[a] cleared on edge when a write port writes a (we && waddr==a);
//   bit[a] set on edge when sb_set_i && sb_addr_i==a && a!=0. Set and clear same addr, same
//   cycle -> set wins (new producer issued). rpend_o[k] combinational from current bits,
//   not bypassed (a write in the current cycle still shows pending until the edge).
//  Entry 0 never written, never pending. Out-of-range never occurs (NREG power of 2).
// TESTING
//  1 rst 1 cycle, NREG=32 -> ready_o=0 for 32 cycles then 1; all reads return 0; rst mid-clear
//    at cycle 10 -> ready_o rises 32 cycles after second rst.
//  2 write x5=0xDEADBEEF via port0, read x5 same cycle -> 0xDEADBEEF (bypass); next cycle
//    from array; READ_REG=1 -> data appears 1 cycle after re asserted.
//  3 we0 x7=0x11, we1 x7=0x22 same cycle -> read x7 = 0x22 same cycle and thereafter.
//  4 write x0=0xFFFFFFFF on both ports -> read x0=0; sb_set x0 -> rpend for x0 stays 0.
//  5 sb_set x9 -> rpend=1 next cycle; write x9 via port1 -> rpend=0 after edge; sb_set x9 +
//    write x9 same cycle -> rpend stays 1.
//  6 NRP=4, all ports reading different regs with re_i=4'b1010 -> ports 0,2 return 0,
//    ports 1,3 return stored values; writes during CLEAR leave entries 0 after READY.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port RV32 integer register file: 2 write ports with write-through bypass, NRP read ports,
// pending-write scoreboard, and a post-reset sequencer that zeroes one entry per cycle.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRP      = 2,
  parameter int READ_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRP-1:0]           re_i,
  input  logic [NRP*$clog2(NREG)-1:0] raddr_i,
  output logic [NRP*XLEN-1:0]      rdata_o,
  output logic [NRP-1:0]           rpend_o,
  input  logic                     we0_i,
  input  logic [$clog2(NREG)-1:0]  waddr0_i,
  input  logic [XLEN-1:0]          wdata0_i,
  input  logic                     we1_i,
  input  logic [$clog2(NREG)-1:0]  waddr1_i,
  input  logic [XLEN-1:0]          wdata1_i,
  input  logic                     sb_set_i,
  input  logic [$clog2(NREG)-1:0]  sb_addr_i,
  output logic                     ready_o
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [AW-1:0]       clr_idx;
  logic [XLEN-1:0]     mem [NREG];
  logic [NREG-1:0]     sb;
  logic [NRP*XLEN-1:0] rd_val;
  logic [AW-1:0]       ra;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(NREG - 1)) begin
            state   <= READY;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= READY;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  // Port 1 is the younger instruction, so its write lands last and wins on a conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else begin
        if (we0_i && waddr0_i != '0) mem[waddr0_i] <= wdata0_i;
        if (we1_i && waddr1_i != '0) mem[waddr1_i] <= wdata1_i;
      end
    end
  end

  // A new producer issued in the same cycle as the old one retires keeps the entry pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else if (state == READY) begin
      for (int a = 1; a < NREG; a++) begin
        if (sb_set_i && sb_addr_i == AW'(a))
          sb[a] <= 1'b1;
        else if ((we0_i && waddr0_i == AW'(a)) || (we1_i && waddr1_i == AW'(a)))
          sb[a] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_val  = '0;
    rpend_o = '0;
    ra      = '0;
    if (state == READY) begin
      for (int k = 0; k < NRP; k++) begin
        ra         = raddr_i[k*AW +: AW];
        rpend_o[k] = sb[ra];
        if (re_i[k] && ra != '0) begin
          if (we1_i && waddr1_i == ra)
            rd_val[k*XLEN +: XLEN] = wdata1_i;
          else if (we0_i && waddr0_i == ra)
            rd_val[k*XLEN +: XLEN] = wdata0_i;
          else
            rd_val[k*XLEN +: XLEN] = mem[ra];
        end
      end
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [NRP*XLEN-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rd_val;
      end
      assign rdata_o = rdata_q;
    end else begin : g_rd_comb
      assign rdata_o = rd_val;
    end
  endgenerate

endmodule
